// File: rtl/qbert_pkg.sv
// Shared types and {x[20:10], y[9:0]} position helpers for the Q*bert disc rider.
package qbert_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        BOARD = 2'b01,
        RIDE  = 2'b10,
        DROP  = 2'b11
    } rider_t;

    typedef enum logic [1:0] {
        RESUME  = 2'b00,
        PAUSE   = 2'b01,
        RESTART = 2'b10
    } game_t;

    typedef logic [1:0] souc_t;
    localparam souc_t SC_START = 2'd0;
    localparam souc_t SC_MOVE  = 2'd1;
    localparam souc_t SC_END   = 2'd2;

    function automatic logic [10:0] xy_x(input logic [20:0] xy);
        return xy[20:10];
    endfunction

    function automatic logic [9:0] xy_y(input logic [20:0] xy);
        return xy[9:0];
    endfunction

    function automatic logic [20:0] xy_pack(input logic [10:0] x, input logic [9:0] y);
        return {x, y};
    endfunction

    // One pixel toward the target; an axis already on target stays put.
    function automatic logic [10:0] step_x(input logic [10:0] cur, input logic [10:0] tgt);
        if (cur < tgt)      return cur + 11'd1;
        else if (cur > tgt) return cur - 11'd1;
        else                return cur;
    endfunction

    function automatic logic [9:0] step_y(input logic [9:0] cur, input logic [9:0] tgt);
        if (cur < tgt)      return cur + 10'd1;
        else if (cur > tgt) return cur - 10'd1;
        else                return cur;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Periodic step tick for the DROP descent; a zero period selects DEFAULT_SPEED.
module step_timer #(
    parameter logic [31:0] DEFAULT_SPEED = 32'd100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        clear,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] count;
    logic [31:0] period_m1;

    assign period_m1 = ((period == 32'd0) ? DEFAULT_SPEED : period) - 32'd1;

    // >= rather than == so a shortened period wraps immediately instead of running to 2^32.
    assign tick = enable && !clear && (count >= period_m1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (clear)
            count <= '0;
        else if (enable)
            count <= tick ? 32'd0 : count + 32'd1;
    end

endmodule

// File: rtl/qbert_disc_rider.sv
// Q*bert side of the flying disc: boards a waiting disc, rides it, then steps down
// onto the pyramid top cube while muxing Q*bert's displayed position.
module qbert_disc_rider
    import qbert_pkg::*;
#(
    parameter int          TOL           = 15,
    parameter logic [10:0] RIDE_DX       = 11'd20,
    parameter logic [31:0] DEFAULT_SPEED = 32'd100000,
    parameter logic [31:0] BOARD_TIMEOUT = 32'd2000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_pause_qb,
    input  logic        e_resume_qb,
    input  logic        e_start_qb,
    input  logic [31:0] e_speed_qb,
    input  logic [20:0] e_XY0_qb,
    input  logic [9:0]  YDIAG_DEMI,
    input  logic [20:0] qbert_xy_in,
    input  logic        jump_done,
    input  logic [20:0] soucoupe_xy,
    input  logic [1:0]  state_sc,
    input  logic        done_move_sc,
    output logic [20:0] qbert_xy_out,
    output logic [1:0]  state_qb,
    output logic        qb_lock,
    output logic        drop_done,
    output logic        board_fail
);

    rider_t      rider;
    game_t       game;
    logic [31:0] board_cnt;
    logic        step_tick;

    logic [10:0] qx, scx, tx, cx, nx, rx;
    logic [9:0]  qy, scy, ty, cy, ny, ry;
    logic signed [11:0] dx, dy, adx, ady;
    logic        near;

    assign qx  = xy_x(qbert_xy_in);
    assign qy  = xy_y(qbert_xy_in);
    assign scx = xy_x(soucoupe_xy);
    assign scy = xy_y(soucoupe_xy);
    assign cx  = xy_x(qbert_xy_out);
    assign cy  = xy_y(qbert_xy_out);

    // 12-bit signed differences so a Q*bert left of / above the disc does not wrap large.
    assign dx   = {1'b0, qx} - {1'b0, scx};
    assign dy   = {2'b00, qy} - ({2'b00, scy} + {2'b00, YDIAG_DEMI});
    assign adx  = dx[11] ? -dx : dx;
    assign ady  = dy[11] ? -dy : dy;
    assign near = (int'(adx) <= TOL) && (int'(ady) <= TOL);

    assign rx = scx - RIDE_DX;
    assign ry = scy + YDIAG_DEMI;
    assign tx = xy_x(e_XY0_qb);
    assign ty = xy_y(e_XY0_qb) + YDIAG_DEMI;
    assign nx = step_x(cx, tx);
    assign ny = step_y(cy, ty);

    assign state_qb = rider;
    assign qb_lock  = (rider != IDLE);

    step_timer #(
        .DEFAULT_SPEED(DEFAULT_SPEED)
    ) u_step_timer (
        .clk    (clk),
        .reset  (reset),
        .enable ((game == RESUME) && (rider == DROP)),
        .clear  ((game == RESTART) || (rider != DROP)),
        .period (e_speed_qb),
        .tick   (step_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rider        <= IDLE;
            game         <= RESUME;
            board_cnt    <= '0;
            qbert_xy_out <= '0;
            drop_done    <= 1'b0;
            board_fail   <= 1'b0;
        end else begin
            drop_done  <= 1'b0;
            board_fail <= 1'b0;

            case (game)
                RESUME:  if (e_pause_qb) game <= PAUSE;
                PAUSE: begin
                    if (e_resume_qb)     game <= RESUME;
                    else if (e_start_qb) game <= RESTART;
                end
                default: game <= RESUME;
            endcase

            if (game == RESTART) begin
                rider     <= IDLE;
                board_cnt <= '0;
            end else if (game == RESUME) begin
                case (rider)
                    IDLE: begin
                        qbert_xy_out <= qbert_xy_in;
                        if (jump_done && (state_sc == SC_START) && near)
                            rider <= BOARD;
                    end
                    BOARD: begin
                        if (state_sc == SC_MOVE) begin
                            rider     <= RIDE;
                            board_cnt <= '0;
                        end else if (board_cnt + 32'd1 == BOARD_TIMEOUT) begin
                            rider      <= IDLE;
                            board_cnt  <= '0;
                            board_fail <= 1'b1;
                        end else begin
                            board_cnt <= board_cnt + 32'd1;
                        end
                    end
                    RIDE: begin
                        qbert_xy_out <= xy_pack(rx, ry);
                        if (done_move_sc || (state_sc == SC_END))
                            rider <= DROP;
                    end
                    DROP: begin
                        if (step_tick) begin
                            qbert_xy_out <= xy_pack(nx, ny);
                            if ((nx == tx) && (ny == ty)) begin
                                drop_done <= 1'b1;
                                rider     <= IDLE;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qbert_disc_rider.sv
// Scoreboard bench for qbert_disc_rider: capture, timeout, ride, drop, pause/restart, async reset.
module tb_qbert_disc_rider;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        e_pause_qb = 1'b0;
    logic        e_resume_qb = 1'b0;
    logic        e_start_qb = 1'b0;
    logic [31:0] e_speed_qb = '0;
    logic [20:0] e_XY0_qb = '0;
    logic [9:0]  ydiag_demi = '0;
    logic [20:0] qbert_xy_in = '0;
    logic        jump_done = 1'b0;
    logic [20:0] soucoupe_xy = '0;
    logic [1:0]  state_sc = '0;
    logic        done_move_sc = 1'b0;
    logic [20:0] qbert_xy_out;
    logic [1:0]  state_qb;
    logic        qb_lock;
    logic        drop_done;
    logic        board_fail;

    qbert_disc_rider #(
        .BOARD_TIMEOUT(32'd100),
        .DEFAULT_SPEED(32'd8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .e_pause_qb   (e_pause_qb),
        .e_resume_qb  (e_resume_qb),
        .e_start_qb   (e_start_qb),
        .e_speed_qb   (e_speed_qb),
        .e_XY0_qb     (e_XY0_qb),
        .YDIAG_DEMI   (ydiag_demi),
        .qbert_xy_in  (qbert_xy_in),
        .jump_done    (jump_done),
        .soucoupe_xy  (soucoupe_xy),
        .state_sc     (state_sc),
        .done_move_sc (done_move_sc),
        .qbert_xy_out (qbert_xy_out),
        .state_qb     (state_qb),
        .qb_lock      (qb_lock),
        .drop_done    (drop_done),
        .board_fail   (board_fail)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_q.push_back(v);
        tag_q.push_back(tag);
    endtask

    task automatic pop_check(input logic [31:0] got);
        check(tag_q.pop_front(), got, exp_q.pop_front());
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [20:0] pk(input int x, input int y);
        return {x[10:0], y[9:0]};
    endfunction

    function automatic logic [31:0] obs();
        return {6'd0, qbert_xy_out, state_qb, qb_lock, drop_done, board_fail};
    endfunction

    function automatic logic [31:0] ex(input logic [20:0] xy, input logic [1:0] st,
                                       input logic lk, input logic dd, input logic bf);
        return {6'd0, xy, st, lk, dd, bf};
    endfunction

    task automatic jump_at(input logic [20:0] q);
        qbert_xy_in = q;
        jump_done   = 1'b1;
        step();
        jump_done   = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int dd_seen;

        #3;
        push("reset_outputs", 32'd0);
        pop_check(obs());
        #10;
        reset = 1'b0;
        step();

        // Capture window against disc {300,200} with half diagonal 30
        soucoupe_xy = pk(300, 200);
        ydiag_demi  = 10'd30;
        state_sc    = 2'd0;
        jump_at(pk(316, 225));
        push("miss_x", ex(pk(316, 225), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());
        jump_at(pk(300, 246));
        push("miss_y", ex(pk(300, 246), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());
        jump_at(pk(285, 245));
        push("capture_edge", ex(pk(285, 245), 2'b01, 1'b1, 1'b0, 1'b0));
        pop_check(obs());

        // Boarding timeout with the disc never leaving START
        n = 0;
        do begin
            step();
            n++;
        end while (!board_fail && n < 200);
        push("board_timeout_cycles", 32'd100);
        pop_check(n);
        push("board_fail_pulse", ex(pk(285, 245), 2'b00, 1'b0, 1'b0, 1'b1));
        pop_check(obs());
        step();
        push("board_fail_clear", ex(pk(285, 245), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());

        // Board then ride, tracking the disc one cycle behind
        jump_at(pk(285, 245));
        state_sc = 2'd1;
        step();
        push("enter_ride", ex(pk(285, 245), 2'b10, 1'b1, 1'b0, 1'b0));
        pop_check(obs());
        for (int scx = 300; scx >= 250; scx -= 5) begin
            soucoupe_xy = pk(scx, 200);
            push("ride_xy", {11'd0, pk(scx - 20, 230)});
            step();
            pop_check({11'd0, qbert_xy_out});
        end

        // Drop with period 4 toward {240,250}
        e_XY0_qb     = pk(240, 220);
        e_speed_qb   = 32'd4;
        done_move_sc = 1'b1;
        step();
        done_move_sc = 1'b0;
        state_sc     = 2'd0;
        push("enter_drop", ex(pk(230, 230), 2'b11, 1'b1, 1'b0, 1'b0));
        pop_check(obs());
        n = 0;
        do begin
            step();
            n++;
            if (n == 3) begin
                push("drop_before_tick", {11'd0, pk(230, 230)});
                pop_check({11'd0, qbert_xy_out});
            end
            if (n == 4) begin
                push("drop_tick1", {11'd0, pk(231, 231)});
                pop_check({11'd0, qbert_xy_out});
            end
            if (n == 40) begin
                push("drop_x_done", {11'd0, pk(240, 240)});
                pop_check({11'd0, qbert_xy_out});
            end
        end while (!drop_done && n < 200);
        push("drop_land_cycles", 32'd80);
        pop_check(n);
        push("drop_land", ex(pk(240, 250), 2'b00, 1'b0, 1'b1, 1'b0));
        pop_check(obs());
        step();
        push("after_land", ex(pk(285, 245), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());

        // Second drop at default period 8, then pause and restart
        soucoupe_xy = pk(300, 200);
        jump_at(pk(285, 245));
        state_sc = 2'd1;
        step();
        e_speed_qb   = 32'd0;
        done_move_sc = 1'b1;
        step();
        done_move_sc = 1'b0;
        state_sc     = 2'd0;
        push("drop2_entry", {11'd0, pk(280, 230)});
        pop_check({11'd0, qbert_xy_out});
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 7) begin
                push("default_period_hold", {11'd0, pk(280, 230)});
                pop_check({11'd0, qbert_xy_out});
            end
            if (i == 8) begin
                push("default_period_tick", {11'd0, pk(279, 231)});
                pop_check({11'd0, qbert_xy_out});
            end
        end
        e_pause_qb = 1'b1;
        step();
        e_pause_qb = 1'b0;
        dd_seen = 0;
        for (int i = 0; i < 500; i++) begin
            step();
            if (drop_done) dd_seen++;
        end
        push("pause_frozen", ex(pk(278, 232), 2'b11, 1'b1, 1'b0, 1'b0));
        pop_check(obs());
        e_resume_qb = 1'b1;
        e_start_qb  = 1'b1;
        step();
        e_resume_qb = 1'b0;
        e_start_qb  = 1'b0;
        e_pause_qb  = 1'b1;
        step();
        e_pause_qb  = 1'b0;
        push("resume_beats_start", ex(pk(278, 232), 2'b11, 1'b1, 1'b0, 1'b0));
        pop_check(obs());
        e_start_qb = 1'b1;
        step();
        e_start_qb = 1'b0;
        step();
        push("restart_idle", ex(pk(278, 232), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());
        e_resume_qb = 1'b1;
        step();
        e_resume_qb = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (drop_done) dd_seen++;
        end
        push("no_drop_after_restart", 32'd0);
        pop_check(dd_seen);
        push("idle_after_restart", ex(pk(285, 245), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());

        // Asynchronous reset in the middle of a ride
        jump_at(pk(285, 245));
        state_sc = 2'd1;
        step();
        step();
        push("ride_before_reset", ex(pk(280, 230), 2'b10, 1'b1, 1'b0, 1'b0));
        pop_check(obs());
        #2;
        reset = 1'b1;
        #1;
        push("async_reset", 32'd0);
        pop_check(obs());
        step();
        reset    = 1'b0;
        state_sc = 2'd0;
        step();
        push("after_reset_idle", ex(pk(285, 245), 2'b00, 1'b0, 1'b0, 1'b0));
        pop_check(obs());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qbert_disc_rider.md
Name: qbert_disc_rider

Overview:
- Q*bert-side counterpart of the flying-disc (soucoupe) layer.
- Detects when Q*bert lands on a waiting disc and drives a non-zero state_qb so the disc starts moving.
- While the disc moves, slaves Q*bert's screen position to the disc; when the disc reports done, steps Q*bert down onto the pyramid top cube and signals landing.
- Sits between the Q*bert jump layer and the soucoupe layer, muxing Q*bert's displayed position.

Parameters:
- TOL, 15, capture tolerance in pixels, per axis, for Q*bert-on-disc detection.
- RIDE_DX, 11'd20, x offset so Q*bert is drawn above the disc centre (qbert_x = disc_x - RIDE_DX).
- DEFAULT_SPEED, 32'd100000, step period in clocks used when e_speed_qb == 0.
- BOARD_TIMEOUT, 32'd2000000, clocks allowed in BOARD before abandoning the boarding attempt.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- e_pause_qb  in  1  game pause request
- e_resume_qb  in  1  resume from pause
- e_start_qb  in  1  restart, honoured only while paused
- e_speed_qb  in  32  step period in clocks; 0 selects DEFAULT_SPEED
- e_XY0_qb  in  21  pyramid top cube origin, {x[20:10], y[9:0]}
- YDIAG_DEMI  in  10  half cube diagonal, vertical
- qbert_xy_in  in  21  Q*bert position from the jump layer
- jump_done  in  1  one-cycle pulse when a Q*bert jump lands
- soucoupe_xy  in  21  disc centre {x,y}
- state_sc  in  2  disc state: 0 START, 1 MOVE, 2 END
- done_move_sc  in  1  disc finished its path (level)
- qbert_xy_out  out  21  displayed Q*bert position
- state_qb  out  2  rider state, exported to the disc layer
- qb_lock  out  1  high in BOARD/RIDE/DROP; the jump layer ignores user input
- drop_done  out  1  one-cycle pulse on landing at the top cube
- board_fail  out  1  one-cycle pulse on BOARD timeout

Behaviour:
- Reset (async): all outputs 0, rider state IDLE, game state RESUME, step counter 0, timeout counter 0.
- Game states:
  - RESUME: normal operation.
  - PAUSE: entered when e_pause_qb is seen in RESUME. All counters and positions freeze and outputs hold.
  - RESTART: entered when e_start_qb is seen in PAUSE. Lasts one cycle, forces IDLE, clears counters, then returns to RESUME.
  - In PAUSE, e_resume_qb takes priority over e_start_qb.
- Rider FSM (state_qb encoding): IDLE=00, BOARD=01, RIDE=10, DROP=11.
- IDLE:
  - qbert_xy_out <= qbert_xy_in (1-cycle latency).
  - Goes to BOARD when all hold in the same cycle: jump_done; state_sc==0; |qx-scx| <= TOL; |qy-(scy+YDIAG_DEMI)| <= TOL.
  - Differences are computed as 12-bit signed values to avoid unsigned wrap.
- BOARD:
  - qbert_xy_out holds its last value; the timeout counter increments.
  - state_sc==1 → RIDE, timeout counter cleared.
  - Counter reaching BOARD_TIMEOUT → IDLE with a one-cycle board_fail pulse.
  - Both in the same cycle → RIDE wins.
- RIDE:
  - Each cycle qbert_xy_out <= {scx - RIDE_DX, scy + YDIAG_DEMI}.
  - Moves to DROP on done_move_sc==1 or state_sc==2, whichever is seen first.
- DROP:
  - Target T = {e_XY0_qb[20:10], e_XY0_qb[9:0] + YDIAG_DEMI}.
  - Step tick fires when the step counter == period-1; the counter then returns to 0. Period = e_speed_qb if nonzero, else DEFAULT_SPEED.
  - On each tick, x and y each move 1 pixel toward T independently; an axis already equal to T does not move.
  - When both axes equal T at a tick → LAND action: one-cycle drop_done, state → IDLE, qb_lock low.
  - If entered with position already equal to T, land on the first tick.
- e_speed_qb changes are sampled every cycle. If the counter is already ≥ the new period-1, it wraps to 0 and emits a tick.
- Arithmetic: x stays 11-bit and y 10-bit; the unsigned scx - RIDE_DX wrap is accepted, with no clamp.
- qb_lock = (state_qb != 00).
- Reset mid-ride returns to IDLE immediately, with no drop_done pulse.

Decomposition:
- Package qbert_pkg:
  - rider_t enum {IDLE, BOARD, RIDE, DROP}
  - game_t enum {RESUME, PAUSE, RESTART}
  - souc_t constants SC_START=0, SC_MOVE=1, SC_END=2
  - XY packing helpers for the {x[20:10], y[9:0]} format
- Sub-module step_timer:
  - Inputs: clk, reset, enable, clear, period[31:0].
  - Output: tick.
  - Generates the DROP step tick; clear is asserted on DROP entry and on RESTART.

Test Plan:
- Capture: scxy={300,200}, YDIAG_DEMI=30, qbert_xy_in={310,225}, state_sc=0, jump_done pulse → state_qb=01 and qb_lock=1 next cycle. Same with qx=316 → stays IDLE.
- Ride tracking: in BOARD, set state_sc=1 → RIDE. Sweep scx 300→250 → qbert_xy_out x = scx-20, y = scy+30, one cycle behind.
- Drop: done_move_sc=1 at qbert {230,230}, e_XY0_qb={240,220}, YDIAG_DEMI=30, e_speed_qb=4 → target {240,250}. Ticks every 4 clocks; x reaches 240 after 10 ticks; drop_done pulses at tick 20 with position {240,250}.
- Timeout: BOARD_TIMEOUT overridden to 100, state_sc held 0 → board_fail pulses at count 100, state_qb=00.
- Pause/restart: pause during DROP → position frozen for 500 clocks; e_start_qb → IDLE, counters 0. Next resume yields no drop_done.
- Async reset asserted mid-RIDE (between clock edges) → all outputs 0 immediately.
